// File: rtl/fsm_exp_arbiter_if.sv
// Requester-side bundle for fsm_exp_arbiter: requests,
// steering codes and the shared FSM's input/output pins.
interface fsm_exp_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [2*NREQ-1:0] req_code;
   logic [3:0]        fsm_outputs;
   logic [1:0]        fsm_inputs;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output req, req_code, fsm_outputs,
      input  fsm_inputs, gnt, busy, done, err
   );

   modport slave (
      input  req, req_code, fsm_outputs,
      output fsm_inputs, gnt, busy, done, err
   );
endinterface

// File: rtl/fsm_exp_arbiter.sv
// Round-robin sequencer for one shared five-state FSM:
// one pass per grant, with timeout and drain-to-s0 flush.
module fsm_exp_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input logic              clk,
   input logic              reset,
   fsm_exp_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [3:0] OUT_S0 = 4'd5;
   localparam logic [3:0] OUT_S4 = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      FLUSH,
      DONE
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] gnt_n;
   logic [1:0]      fi;
   logic [1:0]      fi_n;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   rr_n;
   logic [PW-1:0]   idx;
   logic [PW-1:0]   idx_n;
   logic [PW-1:0]   win;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_n;
   logic            err_q;
   logic            err_n;
   logic            found;
   logic            busy;
   logic            done;
   logic            err;
   int              j;

   // first set request at or above rr_ptr, wrapping
   always_comb begin
      win   = rr_ptr;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(rr_ptr) + i) % NREQ;
         if (!found && bus.req[j]) begin
            win   = PW'(j);
            found = 1'b1;
         end
      end
   end

   // next-state, grant, steering code and pass counter
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      fi_n    = fi;
      rr_n    = rr_ptr;
      idx_n   = idx;
      cnt_n   = cnt;
      err_n   = err_q;
      unique case (state)
         IDLE: begin
            fi_n = 2'b00;
            if (found && bus.fsm_outputs == OUT_S0) begin
               state_n = GRANT;
               idx_n   = win;
               gnt_n   = NREQ'(1) << win;
               fi_n    = bus.req_code[{win, 1'b0} +: 2];
               cnt_n   = '0;
            end
         end
         GRANT: begin
            fi_n  = bus.req_code[{idx, 1'b0} +: 2];
            cnt_n = cnt + CW'(1);
            if (bus.fsm_outputs == OUT_S4) begin
               state_n = DONE;
               err_n   = 1'b0;
               fi_n    = 2'b00;
               cnt_n   = cnt;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_n = FLUSH;
               err_n   = 1'b1;
               fi_n    = 2'b00;
               cnt_n   = cnt;
            end
         end
         FLUSH: begin
            fi_n = 2'b00;
            if (bus.fsm_outputs == OUT_S4 ||
                bus.fsm_outputs == OUT_S0) begin
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
            gnt_n   = '0;
            fi_n    = 2'b00;
            rr_n    = (idx == PW'(NREQ - 1)) ? '0
                    : idx + PW'(1);
         end
         default: state_n = IDLE;
      endcase
      if (state_n == DONE) begin
         gnt_n = '0;
      end
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         gnt    <= '0;
         fi     <= 2'b00;
         rr_ptr <= '0;
         idx    <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         gnt    <= gnt_n;
         fi     <= fi_n;
         rr_ptr <= rr_n;
         idx    <= idx_n;
         cnt    <= cnt_n;
         err_q  <= err_n;
         busy   <= (state_n != IDLE);
         done   <= (state_n == DONE);
         err    <= (state_n == DONE) && err_n;
      end
   end

   assign bus.gnt        = gnt;
   assign bus.fsm_inputs = fi;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.err        = err;
endmodule

// File: tb/tb_fsm_exp_arbiter.sv
// Bench for fsm_exp_arbiter: models the shared five-state
// FSM and checks directed passes plus a random run.
module tb_fsm_exp_arbiter;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   fsm_exp_arbiter_if #(.NREQ(NREQ)) bus ();

   fsm_exp_arbiter #(
      .NREQ(NREQ),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // shared FSM: s0..s4 emit 5, 8, 12, 14, 9
   int         fsm_s = 0;
   logic       fo_force_en = 1'b0;
   logic [3:0] fo_force = 4'd0;

   function automatic logic [3:0] fsm_code(int s);
      case (s)
         0: return 4'd5;
         1: return 4'd8;
         2: return 4'd12;
         3: return 4'd14;
         default: return 4'd9;
      endcase
   endfunction

   function automatic int fsm_next(int s, logic [1:0] c);
      case (s)
         0: return (c == 2'b00) ? 0 : 1;
         1: return (c == 2'b01) ? 1 : (c == 2'b11) ? 3 : 2;
         2: return (c == 2'b10) ? 4 : 3;
         3: return 4;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk) fsm_s <= fsm_next(fsm_s, bus.fsm_inputs);

   assign bus.fsm_outputs = fo_force_en ? fo_force : fsm_code(fsm_s);

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [8:0] obs();
      return {bus.gnt, bus.busy, bus.done, bus.err, bus.fsm_inputs};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      int n;
      reset = 1'b1;
      bus.req = '0;
      bus.req_code = '0;
      step();
      step();
      reset = 1'b0;
      n = 0;
      while (bus.fsm_outputs != 4'd5 && n < 10) begin
         n++;
         step();
      end
      tests++;
      if (bus.fsm_outputs != 4'd5) begin
         fails++;
         $display("FAIL drain: got %0d expected 5", bus.fsm_outputs);
      end
   endtask

   task automatic finish_pass();
      int n;
      bus.req = '0;
      n = 0;
      while (!bus.done && n < 60) begin
         n++;
         step();
      end
      tests++;
      if (bus.done !== 1'b1) begin
         fails++;
         $display("FAIL pass_end: got done=%b expected 1", bus.done);
      end
      step();
   endtask

   // ---------------- reference model for random run
   int         m_ph;
   int         m_w;
   int         m_k;
   int         m_rr;
   logic       m_err;
   logic [3:0] e_gnt;
   logic [1:0] e_fi;
   logic       e_busy;
   logic       e_done;
   logic       e_err;

   function automatic int pick(logic [3:0] r, int rr);
      for (int i = 0; i < NREQ; i++) begin
         if (r[(rr + i) % NREQ]) return (rr + i) % NREQ;
      end
      return rr;
   endfunction

   task automatic model_init();
      m_ph = 0; m_w = 0; m_k = 0; m_rr = 0; m_err = 1'b0;
      e_gnt = '0; e_fi = '0; e_busy = 1'b0;
      e_done = 1'b0; e_err = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r,
                             input logic [7:0] c,
                             input logic [3:0] fo);
      e_done = 1'b0;
      e_err  = 1'b0;
      case (m_ph)
         0: if (r != 0 && fo == 4'd5) begin
            m_w   = pick(r, m_rr);
            m_ph  = 1;
            m_k   = 0;
            e_gnt = 4'(1) << m_w;
            e_fi  = c[2*m_w +: 2];
         end
         1: if (fo == 4'd9) begin
            m_ph = 3; m_err = 1'b0;
         end else if (m_k == TIMEOUT - 1) begin
            m_ph = 2; m_err = 1'b1; e_fi = 2'b00;
         end else begin
            m_k++;
            e_fi = c[2*m_w +: 2];
         end
         2: if (fo == 4'd9 || fo == 4'd5) m_ph = 3;
         default: begin
            m_ph = 0;
            m_rr = (m_w + 1) % NREQ;
         end
      endcase
      if (m_ph == 3) begin
         e_gnt = '0; e_fi = 2'b00;
         e_done = 1'b1; e_err = m_err;
      end
      e_busy = (m_ph != 0);
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      reset = 1'b1;
      bus.req = 4'hF;
      bus.req_code = 8'hAA;
      step();
      tests++;
      if (obs() !== 9'd0) begin
         fails++;
         $display("FAIL reset_vals: got %h expected 000", obs());
      end
      do_reset();
      tests++;
      if (obs() !== 9'd0) begin
         fails++;
         $display("FAIL reset_idle: got %h expected 000", obs());
      end
   endtask

   task automatic test_single();
      logic [3:0] exp_fo [4];
      exp_fo = '{4'd5, 4'd8, 4'd12, 4'd9};
      do_reset();
      bus.req = 4'b0001;
      bus.req_code = 8'hAA;
      step();
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 ||
             bus.fsm_outputs !== exp_fo[k]) begin
            fails++;
            $display("FAIL single_c%0d: got gnt=%b fo=%0d expected 0001 %0d",
                     k, bus.gnt, bus.fsm_outputs, exp_fo[k]);
         end
         step();
      end
      tests++;
      if (obs() !== {4'b0000, 1'b1, 1'b1, 1'b0, 2'b00}) begin
         fails++;
         $display("FAIL single_done: got %h expected 018", obs());
      end
      tests++;
      if (bus.fsm_outputs !== 4'd5) begin
         fails++;
         $display("FAIL single_s0: got %0d expected 5", bus.fsm_outputs);
      end
      bus.req = 4'b0000;
      step();
      tests++;
      if (obs() !== 9'd0) begin
         fails++;
         $display("FAIL single_idle: got %h expected 000", obs());
      end
      bus.req = 4'b0011;
      step();
      tests++;
      if (bus.gnt !== 4'b0010) begin
         fails++;
         $display("FAIL rr_next: got %b expected 0010", bus.gnt);
      end
      finish_pass();
   endtask

   task automatic test_back_to_back();
      int n;
      int m;
      logic [3:0] eg;
      do_reset();
      bus.req = 4'hF;
      bus.req_code = 8'hAA;
      step();
      for (int p = 0; p < 5; p++) begin
         eg = 4'(1) << (p % 4);
         tests++;
         if (bus.gnt !== eg) begin
            fails++;
            $display("FAIL b2b_gnt%0d: got %b expected %b", p, bus.gnt, eg);
         end
         n = 0;
         while (bus.busy && n < 40) begin
            n++;
            step();
         end
         tests++;
         if (n != 5) begin
            fails++;
            $display("FAIL b2b_busy%0d: got %0d expected 5", p, n);
         end
         m = 0;
         while (!bus.busy && m < 40) begin
            m++;
            step();
         end
         tests++;
         if (m != 1) begin
            fails++;
            $display("FAIL b2b_idle%0d: got %0d expected 1", p, m);
         end
      end
      finish_pass();
   endtask

   task automatic test_timeout();
      int g;
      int f;
      logic [3:0] last_fo;
      do_reset();
      bus.req = 4'b0100;
      bus.req_code = 8'b00_01_00_00;
      step();
      bus.req = 4'b0000;
      tests++;
      if (bus.gnt !== 4'b0100) begin
         fails++;
         $display("FAIL to_gnt: got %b expected 0100", bus.gnt);
      end
      g = 0;
      while (bus.busy && bus.fsm_inputs == 2'b01 && g < 40) begin
         g++;
         step();
      end
      tests++;
      if (g != TIMEOUT) begin
         fails++;
         $display("FAIL to_len: got %0d expected %0d", g, TIMEOUT);
      end
      f = 0;
      last_fo = '0;
      while (bus.busy && !bus.done && f < 40) begin
         last_fo = bus.fsm_outputs;
         f++;
         step();
      end
      tests++;
      if (f != 4 || last_fo !== 4'd9) begin
         fails++;
         $display("FAIL flush_len: got %0d/%0d expected 4/9", f, last_fo);
      end
      tests++;
      if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.gnt !== 4'b0) begin
         fails++;
         $display("FAIL to_err: got d=%b e=%b expected 1 1", bus.done, bus.err);
      end
      step();
   endtask

   task automatic test_hold_s0();
      int n;
      do_reset();
      bus.req = 4'b0010;
      bus.req_code = 8'h00;
      step();
      bus.req = 4'b0000;
      n = 0;
      while (!bus.done && n < 40) begin
         n++;
         step();
      end
      tests++;
      if (n != TIMEOUT + 1 || bus.err !== 1'b1) begin
         fails++;
         $display("FAIL hold_s0: got %0d err=%b expected %0d 1",
                  n, bus.err, TIMEOUT + 1);
      end
      step();
      tests++;
      if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse: got d=%b e=%b expected 0 0",
                  bus.done, bus.err);
      end
   endtask

   task automatic test_late_s4();
      int n;
      do_reset();
      bus.req = 4'b0001;
      bus.req_code = 8'b01;
      step();
      n = 0;
      while (!bus.done && n < 40) begin
         bus.req_code = (n >= 12) ? 8'b10 : 8'b01;
         n++;
         step();
      end
      tests++;
      if (n != TIMEOUT || bus.err !== 1'b0 || bus.done !== 1'b1) begin
         fails++;
         $display("FAIL late_s4: got %0d err=%b expected %0d 0",
                  n, bus.err, TIMEOUT);
      end
      bus.req = 4'b0000;
      step();
   endtask

   task automatic test_switch();
      do_reset();
      bus.req = 4'b0001;
      bus.req_code = 8'hAA;
      step();
      for (int k = 0; k < 4; k++) begin
         if (k == 1) bus.req = 4'b1000;
         tests++;
         if (bus.gnt !== 4'b0001) begin
            fails++;
            $display("FAIL sw_hold%0d: got %b expected 0001", k, bus.gnt);
         end
         step();
      end
      tests++;
      if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
         fails++;
         $display("FAIL sw_done: got d=%b e=%b expected 1 0",
                  bus.done, bus.err);
      end
      step();
      step();
      tests++;
      if (bus.gnt !== 4'b1000) begin
         fails++;
         $display("FAIL sw_next: got %b expected 1000", bus.gnt);
      end
      finish_pass();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req = 4'b0001;
      bus.req_code = 8'hAA;
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests++;
      if (obs() !== 9'd0 || bus.fsm_outputs !== 4'd9) begin
         fails++;
         $display("FAIL mid_reset: got %h fo=%0d expected 000 9",
                  obs(), bus.fsm_outputs);
      end
      step();
      tests++;
      if (bus.gnt !== 4'b0000) begin
         fails++;
         $display("FAIL mid_wait: got %b expected 0000", bus.gnt);
      end
      step();
      tests++;
      if (bus.gnt !== 4'b0001) begin
         fails++;
         $display("FAIL mid_regrant: got %b expected 0001", bus.gnt);
      end
      finish_pass();
   endtask

   task automatic test_bad_output();
      do_reset();
      fo_force_en = 1'b1;
      fo_force = 4'd7;
      bus.req = 4'b0100;
      bus.req_code = 8'hAA;
      step();
      step();
      step();
      tests++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL bad_out: got %b expected 0000", bus.gnt);
      end
      fo_force_en = 1'b0;
      step();
      tests++;
      if (bus.gnt !== 4'b0100) begin
         fails++;
         $display("FAIL bad_release: got %b expected 0100", bus.gnt);
      end
      finish_pass();
   endtask

   task automatic test_random();
      logic [7:0] rc;
      logic [8:0] ev;
      int         bad;
      do_reset();
      model_init();
      bad = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         ev = {e_gnt, e_busy, e_done, e_err, e_fi};
         tests++;
         if (obs() !== ev) begin
            fails++;
            bad++;
            if (bad < 10)
               $display("FAIL rand_c%0d: got %h expected %h", cyc, obs(), ev);
         end
         if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
         rc = '0;
         for (int i = 0; i < NREQ; i++) begin
            rc[2*i +: 2] = ($urandom_range(0, 9) < 6) ? 2'b10
                         : 2'($urandom);
         end
         bus.req_code = rc;
         model_step(bus.req, bus.req_code, bus.fsm_outputs);
         step();
      end
   endtask

   initial begin
      bus.req = '0;
      bus.req_code = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_timeout();
      test_hold_s0();
      test_late_s4();
      test_switch();
      test_reset_mid();
      test_bad_output();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
